// File: rtl/uart_rx_if.sv
// Serial-receiver bus: line and baud enable in, received byte and status out.
interface uart_rx_if;
  logic       rx_serial;
  logic       baud_tick;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  // Side that drives the serial line and consumes received frames.
  modport master (
    output rx_serial, baud_tick,
    input  rx_data, rx_valid, parity_err, frame_err, busy
  );

  // The receiver itself.
  modport slave (
    input  rx_serial, baud_tick,
    output rx_data, rx_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampling, 8 data bits, optional parity, one stop bit.
// Start bit is confirmed at mid-bit; every later bit is sampled 16 ticks on,
// so each sample lands near the middle of its bit.
module uart_rx #(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic    clock,
  input  logic    reset,
  uart_rx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_mis_q, par_mis_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       rx_meta, rx_sync;

  // Two-flop synchronizer; flops reset to the idle (high) line level.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch, not the sensitivity list.
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here keep rx_sync one full cycle behind rx_meta.
      rx_meta <= bus.rx_serial;
      rx_sync <= rx_meta;
    end
  end

  // Next-state and datapath: nothing moves unless baud_tick is high.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_mis_d = par_mis_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    if (bus.baud_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_sync) begin
            state_d = START;
            tick_d  = 4'd0;
          end
        end
        START: begin
          if (tick_q == 4'd7) begin
            tick_d  = 4'd0;
            bit_d   = 3'd0;
            // A line back high at mid-start was a glitch: drop it silently.
            state_d = rx_sync ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        DATA: begin
          // Counter wraps 15 -> 0 on its own, giving the next bit's 16 ticks.
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            shift_d = {rx_sync, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = PARITY_EN ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            par_mis_d = rx_sync ^ (^shift_q) ^ PARITY_ODD;
            state_d   = STOP;
          end
        end
        STOP: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = PARITY_EN ? par_mis_q : 1'b0;
            ferr_d  = ~rx_sync;
            // A low stop bit means a break; wait for the line to recover.
            state_d = rx_sync ? IDLE : BREAK;
          end
        end
        BREAK: begin
          if (rx_sync) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      tick_q    <= 4'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      par_mis_q <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_mis_q <= par_mis_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance with even parity, one without.
module tb_uart_rx;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } frame_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       baud_tick = 1'b0;
  logic [1:0] tick_div = 2'd0;
  logic       line_p = 1'b1;
  logic       line_n = 1'b1;

  int checks = 0;
  int errors = 0;

  frame_t frames_p[$];
  frame_t frames_n[$];

  uart_rx_if u_if_p ();
  uart_rx_if u_if_n ();

  assign u_if_p.rx_serial = line_p;
  assign u_if_p.baud_tick = baud_tick;
  assign u_if_n.rx_serial = line_n;
  assign u_if_n.baud_tick = baud_tick;

  uart_rx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_p (
    .clock (clock),
    .reset (reset),
    .bus   (u_if_p.slave)
  );

  uart_rx #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut_n (
    .clock (clock),
    .reset (reset),
    .bus   (u_if_n.slave)
  );

  always #5 clock = ~clock;

  // One baud tick every 4 clocks, changed on the falling edge.
  always @(negedge clock) begin
    tick_div  = tick_div + 2'd1;
    baud_tick = (tick_div == 2'd0);
  end

  // Record every clock where rx_valid is high.
  always @(negedge clock) begin
    if (u_if_p.rx_valid === 1'b1)
      frames_p.push_back('{u_if_p.rx_data, u_if_p.parity_err, u_if_p.frame_err});
    if (u_if_n.rx_valid === 1'b1)
      frames_n.push_back('{u_if_n.rx_data, u_if_n.parity_err, u_if_n.frame_err});
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; ) begin
      @(posedge clock);
      if (baud_tick) i++;
    end
    @(negedge clock);
  endtask

  task automatic set_line(input bit sel, input logic b);
    if (sel) line_n = b;
    else     line_p = b;
  endtask

  // Leaves the line at the stop-bit level on return.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                            input logic par_bit, input logic stop_bit);
    set_line(sel, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      wait_ticks(16);
    end
    if (use_par) begin
      set_line(sel, par_bit);
      wait_ticks(16);
    end
    set_line(sel, stop_bit);
    wait_ticks(16);
  endtask

  task automatic check_frame(input string tag, input bit sel, input int idx,
                             input logic [7:0] d, input logic pe, input logic fe);
    frame_t f;
    f = '{data: 'x, pe: 'x, fe: 'x};
    if (sel) begin
      if (idx < frames_n.size()) f = frames_n[idx];
    end else begin
      if (idx < frames_p.size()) f = frames_p[idx];
    end
    check({tag, " data"}, {24'd0, f.data}, {24'd0, d});
    check({tag, " parity_err"}, {31'd0, f.pe}, {31'd0, pe});
    check({tag, " frame_err"}, {31'd0, f.fe}, {31'd0, fe});
  endtask

  initial begin
    repeat (4) @(negedge clock);
    check("reset rx_data", {24'd0, u_if_p.rx_data}, 32'h00);
    check("reset rx_valid", {31'd0, u_if_p.rx_valid}, 32'd0);
    check("reset parity_err", {31'd0, u_if_p.parity_err}, 32'd0);
    check("reset frame_err", {31'd0, u_if_p.frame_err}, 32'd0);
    check("reset busy", {31'd0, u_if_p.busy}, 32'd0);
    reset = 1'b1;
    wait_ticks(20);

    // 0xA5 has four ones: even parity bit 0.
    send_frame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1);
    wait_ticks(16);
    check("a5 count", frames_p.size(), 32'd1);
    check_frame("a5", 1'b0, 0, 8'hA5, 1'b0, 1'b0);
    check("a5 busy after", {31'd0, u_if_p.busy}, 32'd0);

    // 0x3C has four ones: parity bit 1 is wrong for even.
    send_frame(1'b0, 8'h3C, 1'b1, 1'b1, 1'b1);
    wait_ticks(16);
    check("3c count", frames_p.size(), 32'd2);
    check_frame("3c", 1'b0, 1, 8'h3C, 1'b1, 1'b0);
    wait_ticks(48);
    check("3c hold data", {24'd0, u_if_p.rx_data}, 32'h3C);
    check("3c hold parity_err", {31'd0, u_if_p.parity_err}, 32'd1);

    // 0x01 has one one: parity bit 1 correct; stop low, then a long break.
    send_frame(1'b0, 8'h01, 1'b1, 1'b1, 1'b0);
    wait_ticks(40 * 16);
    check("brk count", frames_p.size(), 32'd3);
    check_frame("brk", 1'b0, 2, 8'h01, 1'b0, 1'b1);
    check("brk busy", {31'd0, u_if_p.busy}, 32'd1);
    set_line(1'b0, 1'b1);
    wait_ticks(32);
    check("brk end count", frames_p.size(), 32'd3);
    check("brk end busy", {31'd0, u_if_p.busy}, 32'd0);
    // 0x80 has one one: parity bit 1.
    send_frame(1'b0, 8'h80, 1'b1, 1'b1, 1'b1);
    wait_ticks(16);
    check("post brk count", frames_p.size(), 32'd4);
    check_frame("post brk", 1'b0, 3, 8'h80, 1'b0, 1'b0);

    // Glitch: four ticks low, then high before the mid-start sample.
    set_line(1'b0, 1'b0);
    wait_ticks(3);
    check("glitch busy", {31'd0, u_if_p.busy}, 32'd1);
    wait_ticks(1);
    set_line(1'b0, 1'b1);
    wait_ticks(16);
    check("glitch busy after", {31'd0, u_if_p.busy}, 32'd0);
    check("glitch count", frames_p.size(), 32'd4);

    // Reset in the middle of bit 4 of 0xFF.
    set_line(1'b0, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      set_line(1'b0, 1'b1);
      wait_ticks(16);
    end
    wait_ticks(8);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    check("rst rx_data", {24'd0, u_if_p.rx_data}, 32'h00);
    check("rst busy", {31'd0, u_if_p.busy}, 32'd0);
    wait_ticks(64);
    check("rst count", frames_p.size(), 32'd4);
    // 0x5A has four ones: parity bit 0.
    send_frame(1'b0, 8'h5A, 1'b1, 1'b0, 1'b1);
    wait_ticks(16);
    check("5a count", frames_p.size(), 32'd5);
    check_frame("5a", 1'b0, 4, 8'h5A, 1'b0, 1'b0);

    // No-parity instance: back-to-back frames with no idle gap.
    send_frame(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    wait_ticks(16);
    check("np count", frames_n.size(), 32'd2);
    check_frame("np first", 1'b1, 0, 8'h00, 1'b0, 1'b0);
    check_frame("np second", 1'b1, 1, 8'hFF, 1'b0, 1'b0);
    check("np other count", frames_p.size(), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
